// File: rtl/ber_pkg.sv
// Shared types and constants for the BER measurement-window controller.
package ber_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StMeasure,
    StLatch
  } state_e;

  localparam int unsigned CLR_CYC         = 2;
  localparam int unsigned INV_CHECK_WORDS = 16;
  localparam int unsigned INV_ERR_SHIFT   = 5;

  // A zero window would never latch, so it is promoted to one word.
  function automatic logic [57:0] win_target(input logic [57:0] win);
    return (win == '0) ? 58'd1 : win;
  endfunction

endpackage

// File: rtl/stall_watch.sv
// Dead-link detector: flags when CNT has held still for STALL_CYC consecutive cycles.
module stall_watch #(
  parameter int unsigned STALL_CYC = 1024
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        RESTART,
  input  logic [57:0] CNT,
  output logic        STALL
);

  localparam int unsigned CntW = $clog2(STALL_CYC + 1);

  logic [57:0]     prev_q, prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            same;

  assign same = (CNT == prev_q);

  always_comb begin
    prev_d = CNT;
    cnt_d  = cnt_q;
    if (RESTART || !same) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(STALL_CYC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the cycle that completes the STALL_CYC-th unchanged sample.
  assign STALL = !RESTART && same && (cnt_q >= CntW'(STALL_CYC - 1));

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ber_window.sv
// Runs one bounded BER measurement per START against lvds1's counters and latches a verdict.
module ber_window
  import ber_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned STALL_CYC  = 1024
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        START,
  input  logic        ABORT,
  input  logic        AUTO_INV,
  input  logic        INV_INIT,
  input  logic [57:0] WINDOW,
  input  logic [63:0] ERR_MAX,
  input  logic [63:0] ERR_CNT,
  input  logic [57:0] RECV_CNT,
  output logic        CLR,
  output logic        INV,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic        STALL,
  output logic [63:0] RES_ERR,
  output logic [57:0] RES_RECV
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        clr_q, clr_d;
  logic        inv_q, inv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        stall_q, stall_d;
  logic [63:0] res_err_q, res_err_d;
  logic [57:0] res_recv_q, res_recv_d;
  logic        tried_q, tried_d;
  logic        chk_q, chk_d;

  logic        link_stall;
  logic        enough_words;
  logic        inv_fire;

  stall_watch #(
    .STALL_CYC(STALL_CYC)
  ) u_stall_watch (
    .CLK    (CLK),
    .RSTX   (RSTX),
    .RESTART(state_q != StMeasure),
    .CNT    (RECV_CNT),
    .STALL  (link_stall)
  );

  assign enough_words = (RECV_CNT >= 58'(INV_CHECK_WORDS));
  // Inverted link looks like more than half the bits wrong; judged once per run.
  assign inv_fire = AUTO_INV && !tried_q && !chk_q && enough_words &&
                    (ERR_CNT > (64'(RECV_CNT) << INV_ERR_SHIFT));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    stall_d    = stall_q;
    res_err_d  = res_err_q;
    res_recv_d = res_recv_q;
    tried_d    = tried_q;
    chk_d      = chk_q;

    if (ABORT && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_d = StClear;
            cnt_d   = '0;
            inv_d   = INV_INIT;
            tried_d = 1'b0;
            stall_d = 1'b0;
            chk_d   = 1'b0;
          end
        end
        StClear: begin
          if (cnt_q == 32'(CLR_CYC - 1)) begin
            state_d = StSettle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StSettle: begin
          if (cnt_q == 32'(SETTLE_CYC - 1)) begin
            state_d = StMeasure;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StMeasure: begin
          if (enough_words) begin
            chk_d = 1'b1;
          end
          if (link_stall) begin
            state_d    = StLatch;
            stall_d    = 1'b1;
            pass_d     = 1'b0;
            done_d     = 1'b1;
            res_err_d  = ERR_CNT;
            res_recv_d = RECV_CNT;
          end else if (inv_fire) begin
            state_d = StClear;
            cnt_d   = '0;
            inv_d   = !inv_q;
            tried_d = 1'b1;
          end else if (RECV_CNT >= win_target(WINDOW)) begin
            state_d    = StLatch;
            pass_d     = (ERR_CNT <= ERR_MAX);
            done_d     = 1'b1;
            res_err_d  = ERR_CNT;
            res_recv_d = RECV_CNT;
          end
        end
        StLatch: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    clr_d  = (state_d == StClear);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_q      <= 1'b1;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      stall_q    <= 1'b0;
      res_err_q  <= '0;
      res_recv_q <= '0;
      tried_q    <= 1'b0;
      chk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_q      <= clr_d;
      inv_q      <= inv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      stall_q    <= stall_d;
      res_err_q  <= res_err_d;
      res_recv_q <= res_recv_d;
      tried_q    <= tried_d;
      chk_q      <= chk_d;
    end
  end

  assign CLR      = clr_q;
  assign INV      = inv_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign STALL    = stall_q;
  assign RES_ERR  = res_err_q;
  assign RES_RECV = res_recv_q;

endmodule

// File: tb/tb_ber_window.sv
// Scoreboard bench for ber_window with a simple lvds1 counter model.
module tb_ber_window;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        auto_inv;
  logic        inv_init;
  logic [57:0] window;
  logic [63:0] err_max;
  logic [63:0] err_cnt;
  logic [57:0] recv_cnt;
  logic        clr;
  logic        inv;
  logic        busy;
  logic        done;
  logic        pass;
  logic        stall;
  logic [63:0] res_err;
  logic [57:0] res_recv;

  ber_window #(
    .SETTLE_CYC(16),
    .STALL_CYC (1024)
  ) dut (
    .CLK     (clk),
    .RSTX    (rst_n),
    .START   (start),
    .ABORT   (abort),
    .AUTO_INV(auto_inv),
    .INV_INIT(inv_init),
    .WINDOW  (window),
    .ERR_MAX (err_max),
    .ERR_CNT (err_cnt),
    .RECV_CNT(recv_cnt),
    .CLR     (clr),
    .INV     (inv),
    .BUSY    (busy),
    .DONE    (done),
    .PASS    (pass),
    .STALL   (stall),
    .RES_ERR (res_err),
    .RES_RECV(res_recv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lvds1 model: one word per cycle after a 16-cycle latency; errors per word depend on INV.
  localparam int unsigned MLat = 16;
  logic [63:0] m_inc0, m_inc1, m_cap;
  logic [57:0] m_freeze;
  int unsigned m_lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_cnt <= '0;
      err_cnt  <= '0;
      m_lat    <= 0;
    end else if (clr) begin
      recv_cnt <= '0;
      err_cnt  <= '0;
      m_lat    <= 0;
    end else if (m_lat < MLat) begin
      m_lat <= m_lat + 1;
    end else if (recv_cnt != m_freeze) begin
      recv_cnt <= recv_cnt + 58'd1;
      err_cnt  <= ((err_cnt + (inv ? m_inc1 : m_inc0)) > m_cap) ? m_cap :
                  (err_cnt + (inv ? m_inc1 : m_inc0));
    end
  end

  typedef struct {
    logic        pass;
    logic        stall;
    logic [63:0] err;
    logic [57:0] recv;
    logic        inv;
    int          clr_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   clr_cnt = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic s, input logic [63:0] e,
                              input logic [57:0] r, input logic i, input int c);
    exp_t x;
    x.pass = p; x.stall = s; x.err = e; x.recv = r; x.inv = i; x.clr_cyc = c;
    return x;
  endfunction

  // Monitor: counts CLR-high cycles within a run and checks results on each DONE.
  initial begin
    forever begin
      @(negedge clk);
      if (!busy) clr_cnt = 0;
      else if (clr) clr_cnt++;
      if (done) begin
        chk("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("pass",     64'(pass),     64'(mon_e.pass));
          chk("stall",    64'(stall),    64'(mon_e.stall));
          chk("res_err",  res_err,       mon_e.err);
          chk("res_recv", 64'(res_recv), 64'(mon_e.recv));
          chk("inv",      64'(inv),      64'(mon_e.inv));
          chk("clr_cyc",  64'(clr_cnt),  64'(mon_e.clr_cyc));
        end
      end
    end
  end

  task automatic set_run(input logic a, input logic ii, input logic [57:0] w,
                         input logic [63:0] em, input logic [63:0] i0, input logic [63:0] i1,
                         input logic [63:0] cap, input logic [57:0] frz);
    auto_inv = a; inv_init = ii; window = w; err_max = em;
    m_inc0 = i0; m_inc1 = i1; m_cap = cap; m_freeze = frz;
  endtask

  // Leaves the caller at the negedge of cycle N+1 (START sampled at edge N).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completes"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  localparam logic [63:0] Big  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [57:0] NoFz = 58'h3FF_FFFF_FFFF_FFFF;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_run(1'b0, 1'b0, 58'd100, 64'd0, 64'd0, 64'd0, Big, NoFz);
    repeat (3) @(negedge clk);
    chk("rst_clr",      64'(clr),      64'd1);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_pass",     64'(pass),     64'd0);
    chk("rst_inv",      64'(inv),      64'd0);
    chk("rst_stall",    64'(stall),    64'd0);
    chk("rst_res_err",  res_err,       64'd0);
    chk("rst_res_recv", 64'(res_recv), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_clr_low", 64'(clr), 64'd0);

    // Clean link, window 100, with START-to-SETTLE timing.
    sb.push_back(mk(1'b1, 1'b0, 64'd0, 58'd100, 1'b0, 2));
    pulse_start();
    chk("n1_busy", 64'(busy), 64'd1);
    chk("n1_clr",  64'(clr),  64'd1);
    @(negedge clk);
    chk("n2_clr",  64'(clr),  64'd1);
    @(negedge clk);
    chk("n3_clr",  64'(clr),  64'd0);
    chk("n3_busy", 64'(busy), 64'd1);
    wait_idle("basic");

    // Five errors against limits 4 and 5.
    set_run(1'b0, 1'b0, 58'd100, 64'd4, 64'd1, 64'd1, 64'd5, NoFz);
    sb.push_back(mk(1'b0, 1'b0, 64'd5, 58'd100, 1'b0, 2));
    pulse_start();
    wait_idle("err5_max4");
    err_max = 64'd5;
    sb.push_back(mk(1'b1, 1'b0, 64'd5, 58'd100, 1'b0, 2));
    pulse_start();
    wait_idle("err5_max5");

    // Inverted link recovered by one retry; polarity kept afterwards.
    set_run(1'b1, 1'b0, 58'd100, 64'd0, 64'd64, 64'd0, Big, NoFz);
    sb.push_back(mk(1'b1, 1'b0, 64'd0, 58'd100, 1'b1, 4));
    pulse_start();
    wait_idle("autoinv");
    chk("inv_retained", 64'(inv), 64'd1);

    // Dead link: count frozen at 7.
    set_run(1'b0, 1'b0, 58'd100, 64'd0, 64'd0, 64'd0, Big, 58'd7);
    sb.push_back(mk(1'b0, 1'b1, 64'd0, 58'd7, 1'b0, 2));
    pulse_start();
    wait_idle("stall");

    // Errors regardless of polarity: one retry only, then fail.
    set_run(1'b1, 1'b0, 58'd100, 64'd0, 64'd64, 64'd64, Big, NoFz);
    sb.push_back(mk(1'b0, 1'b0, 64'd6400, 58'd100, 1'b1, 4));
    pulse_start();
    wait_idle("stuck_inv");

    // Abort in SETTLE, then in MEASURE: no DONE, results untouched.
    set_run(1'b0, 1'b0, 58'd100, 64'd0, 64'd0, 64'd0, Big, NoFz);
    pulse_start();
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_settle_busy", 64'(busy), 64'd0);
    chk("abort_settle_clr",  64'(clr),  64'd0);
    chk("abort_settle_err",  res_err,   64'd6400);
    chk("abort_settle_recv", 64'(res_recv), 64'd100);
    pulse_start();
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_meas_busy", 64'(busy), 64'd0);
    chk("abort_meas_clr",  64'(clr),  64'd0);
    chk("abort_meas_pass", 64'(pass), 64'd0);
    chk("abort_meas_recv", 64'(res_recv), 64'd100);
    repeat (150) @(negedge clk);

    // ABORT alone while idle does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_busy", 64'(busy), 64'd0);

    // START while busy is ignored: no extra clear, same result.
    sb.push_back(mk(1'b1, 1'b0, 64'd0, 58'd100, 1'b0, 2));
    pulse_start();
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_clr", 64'(clr), 64'd0);
    wait_idle("start_busy");

    // START and ABORT together in IDLE: START wins; WINDOW 0 completes at one word.
    set_run(1'b0, 1'b0, 58'd0, 64'd0, 64'd0, 64'd0, Big, NoFz);
    sb.push_back(mk(1'b1, 1'b0, 64'd0, 58'd1, 1'b0, 2));
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd1);
    chk("start_abort_clr",  64'(clr),  64'd1);
    wait_idle("window0");

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ber_window.md
# ber_window

Measurement-window controller for the LVDS bit-error-rate link, living in the parallel clock domain downstream of `lvds1`. It drives `lvds1`'s `CLR` and `INV`, consumes `ERR_CNT`/`RECV_CNT`, and runs one bounded measurement per `START`. Each run clears the counters, waits out pipeline latency and accumulates until a word target is reached. It then latches the results with a pass/fail verdict. Optionally, it auto-detects an inverted link and retries once with `INV` toggled.

## Interface
Parameters:
- `SETTLE_CYC`, default 16: cycles after `CLR` release before measuring. Covers FIFO/align latency. Must be ≥1.
- `STALL_CYC`, default 1024: consecutive cycles with `RECV_CNT` unchanged that declare a dead link. Must be ≥2.

Ports:
- `CLK`  in  1  parallel clock (same as lvds1 `CLKP`)
- `RSTX`  in  1  reset, asynchronous, active-low
- `START`  in  1  one-cycle request; ignored unless idle
- `ABORT`  in  1  cancel current run
- `AUTO_INV`  in  1  enable inverted-link detection/retry
- `INV_INIT`  in  1  polarity loaded into `INV` on accepted `START`
- `WINDOW`  in  58  target received words; 0 treated as 1
- `ERR_MAX`  in  64  max bit errors for pass (inclusive)
- `ERR_CNT`  in  64  bit-error count from lvds1
- `RECV_CNT`  in  58  received 64-bit word count from lvds1
- `CLR`  out  1  counter clear to lvds1
- `INV`  out  1  receive polarity to lvds1
- `BUSY`  out  1  high in any state except IDLE
- `DONE`  out  1  one-cycle pulse, results valid
- `PASS`  out  1  verdict of last completed run
- `STALL`  out  1  last run ended by stall timeout
- `RES_ERR`  out  64  latched `ERR_CNT`
- `RES_RECV`  out  58  latched `RECV_CNT`

## Operation
- States: IDLE, CLEAR, SETTLE, MEASURE, LATCH.
- **IDLE:**
  - `START` → CLEAR.
  - Load `INV` ← `INV_INIT`.
  - Clear the `inv_tried` flag.
  - Clear `STALL`.
- **CLEAR:**
  - `CLR`=1 for exactly 2 cycles.
  - Then → SETTLE.
- **SETTLE:**
  - `CLR`=0.
  - Count `SETTLE_CYC` cycles, then → MEASURE.
  - Reset the stall counter on entry.
- **MEASURE, evaluated each cycle in priority order:**
  1. Stall: `RECV_CNT` equals its previous-cycle value for `STALL_CYC` consecutive cycles. Set `STALL`=1 and go → LATCH. Any change in `RECV_CNT` restarts the stall count.
  2. Auto-inv: all of the following must hold.
     - `AUTO_INV`=1 and `inv_tried`=0.
     - `RECV_CNT` ≥ 16.
     - `ERR_CNT` > `RECV_CNT`×32, i.e. more than half the received bits are in error. Compare at 64 bits: `{1'b0, RECV_CNT, 5'b0}`.

     Then toggle `INV`, set `inv_tried`, and go → CLEAR. This check is made once only, at the first cycle where `RECV_CNT` ≥ 16.
  3. Window: `RECV_CNT` ≥ max(`WINDOW`,1) → LATCH.
- **LATCH (1 cycle):**
  - `RES_ERR` ← `ERR_CNT`, `RES_RECV` ← `RECV_CNT`.
  - `PASS` ← !`STALL` && (`ERR_CNT` ≤ `ERR_MAX`).
  - `DONE`=1.
  - → IDLE.
- **ABORT:**
  - From any non-IDLE state → IDLE next cycle. `CLR`=0.
  - No `DONE` pulse. `RES_*`/`PASS`/`STALL` unchanged.
  - `INV` keeps its current value.
  - `ABORT` has priority over every transition. `ABORT` in IDLE has no effect.
- `START` while `BUSY` is ignored. `START` and `ABORT` in the same IDLE cycle: `START` wins.
- `INV` holds its value after a run completes, so the tuned polarity persists until the next `START`.
- Reset values:
  - State IDLE.
  - `CLR`=1, keeping lvds1 counters cleared under reset.
  - All other outputs 0: `INV`, `BUSY`, `DONE`, `PASS`, `STALL`, `RES_ERR`, `RES_RECV`.
  - The first IDLE cycle after reset drives `CLR`=0.

## Timing
- `START` sampled at edge N:
  - `BUSY` and `CLR` high from N+1.
  - `CLR` high for cycles N+1 and N+2.
  - SETTLE occupies N+3 … N+2+`SETTLE_CYC`.
  - MEASURE starts at N+3+`SETTLE_CYC`.
- Window/stall condition true in MEASURE cycle M: LATCH at M+1. `DONE`, `RES_*`, `PASS` and `STALL` are valid at M+1. `BUSY`=0 at M+2.
- Auto-inv retry: `INV` toggles and `CLR` rises in the same cycle, at M+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `ber_pkg`:
  - state enum.
  - `CLR_CYC`=2.
  - `INV_CHECK_WORDS`=16.
  - `INV_ERR_SHIFT`=5.
- Sub-module `stall_watch`:
  - Ports: `CLK`, `RSTX`, `RESTART`, `CNT[57:0]`, `STALL` (pulse).
  - Holds the previous-count register and the saturating counter of width $clog2(`STALL_CYC`+1).

## Test plan
- Reset, then `START` with `SETTLE_CYC`=16. Model counts +1 word/cycle with 0 errors, `WINDOW`=100, `ERR_MAX`=0.
  → `CLR` high exactly 2 cycles; `DONE` once; `PASS`=1; `RES_RECV`=100 and `RES_ERR`=0 at the latch cycle.
- Same run, but the model injects 5 errors; `ERR_MAX`=4 → `PASS`=0, `RES_ERR`=5. Rerun with `ERR_MAX`=5 → `PASS`=1.
- `AUTO_INV`=1, `INV_INIT`=0. Model produces 64 errors per word when `INV`=0 and 0 errors when `INV`=1.
  → At `RECV_CNT`=16, `INV` becomes 1 and `CLR` re-pulses; final `PASS`=1, `INV`=1 retained. With `INV` stuck inverted, there is no second retry and `PASS`=0.
- `RECV_CNT` frozen at 7 after SETTLE, `STALL_CYC`=1024 → after 1024 unchanged cycles: `DONE`, `STALL`=1, `PASS`=0, `RES_RECV`=7.
- `ABORT` during SETTLE and during MEASURE → IDLE next cycle, `CLR`=0, no `DONE`, previous `RES_*` unchanged. `START` during `BUSY` is ignored. `WINDOW`=0 completes at `RECV_CNT`=1.
